// File: rtl/mem_bank_array_if.sv
// Bus bundle for mem_bank_array: host port A, core port B, clear engine and collision monitor.
// The slave modport is used by the bank array, the master modport by whatever drives it.
interface mem_bank_array_if #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 14
);
    localparam int BSEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic              a_req;
    logic              a_ready;
    logic [BSEL_W-1:0] a_bank;
    logic [ADDR_W-1:0] a_addr;
    logic              a_we;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              a_perr;

    logic              b_req;
    logic              b_ready;
    logic [BSEL_W-1:0] b_bank;
    logic [ADDR_W-1:0] b_addr;
    logic              b_we;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              b_perr;

    logic              clear_start;
    logic [BSEL_W-1:0] clear_bank;
    logic              clear_busy;
    logic              clear_done;

    logic              collision_clr;
    logic [15:0]       collision_cnt;
    logic              collision_flag;

    modport slave (
        input  a_req, a_bank, a_addr, a_we, a_wdata,
        output a_ready, a_ack, a_rdata, a_perr,
        input  b_req, b_bank, b_addr, b_we, b_wdata,
        output b_ready, b_ack, b_rdata, b_perr,
        input  clear_start, clear_bank,
        output clear_busy, clear_done,
        input  collision_clr,
        output collision_cnt, collision_flag
    );

    modport master (
        output a_req, a_bank, a_addr, a_we, a_wdata,
        input  a_ready, a_ack, a_rdata, a_perr,
        output b_req, b_bank, b_addr, b_we, b_wdata,
        input  b_ready, b_ack, b_rdata, b_perr,
        output clear_start, clear_bank,
        input  clear_busy, clear_done,
        output collision_clr,
        input  collision_cnt, collision_flag
    );
endinterface

// File: rtl/mem_bank_array.sv
// Array of NUM_BANKS dual-port RAMs shared by host port A and core port B, with a zero-fill
// clear engine and same-address collision counting. Optional parity via MEMBANK_PARITY_EN.
module mem_bank_array #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 14
) (
    input logic            sysclk,
    input logic            arduino_reset_n,
    mem_bank_array_if.slave bus
);
    localparam int BSEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int DEPTH  = 2 ** ADDR_W;
`ifdef MEMBANK_PARITY_EN
    localparam int MEM_W  = DATA_W + 1;
`else
    localparam int MEM_W  = DATA_W;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clear_state_t;

    clear_state_t      state_q, state_d;
    logic [BSEL_W-1:0] clr_bank_q, clr_bank_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clearing;
    logic              clear_done_s;

    logic a_ready_s, b_ready_s;
    logic a_acc, b_acc;
    logic collision;

    logic [NUM_BANKS-1:0][MEM_W-1:0] qa_all, qb_all;

    logic              a_v1, a_rd1, a_ok1;
    logic [BSEL_W-1:0] a_bank1;
    logic              b_v1, b_rd1, b_ok1;
    logic [BSEL_W-1:0] b_bank1;

    logic              a_ack_q, b_ack_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
    logic              a_perr_q, b_perr_q;

    logic [15:0]       coll_cnt_q;
    logic              coll_flag_q;

    function automatic logic in_range(input logic [BSEL_W-1:0] b);
        return int'(b) < NUM_BANKS;
    endfunction

    // Stored word layout: {even parity bit, data} when parity is enabled, plain data otherwise.
    function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef MEMBANK_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    always_ff @(posedge sysclk or negedge arduino_reset_n) begin
        if (!arduino_reset_n) begin
            state_q    <= IDLE;
            clr_bank_q <= '0;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_bank_q <= clr_bank_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_bank_d   = clr_bank_q;
        clr_addr_d   = clr_addr_q;
        clearing     = 1'b0;
        clear_done_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear_start) begin
                    state_d    = CLEAR;
                    clr_bank_d = bus.clear_bank;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                clearing   = 1'b1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                clear_done_s = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Only the bank being zero-filled stalls; the rest of the array keeps serving both ports.
    assign a_ready_s = !(clearing && bus.a_bank == clr_bank_q);
    assign b_ready_s = !(clearing && bus.b_bank == clr_bank_q);
    assign a_acc     = bus.a_req && a_ready_s;
    assign b_acc     = bus.b_req && b_ready_s;

    assign collision = a_acc && b_acc && (bus.a_bank == bus.b_bank)
                       && (bus.a_addr == bus.b_addr) && (bus.a_we || bus.b_we);

    // The clear engine borrows port A of the locked bank, which the host cannot reach meanwhile.
    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        logic [MEM_W-1:0]  mem [DEPTH];
        logic [MEM_W-1:0]  qa, qb;
        logic              clr_here;
        logic              pa_en, pa_we, pb_en;
        logic [ADDR_W-1:0] pa_addr;
        logic [MEM_W-1:0]  pa_wdata;

        assign clr_here = clearing && (clr_bank_q == BSEL_W'(k));
        assign pa_en    = clr_here || (a_acc && bus.a_bank == BSEL_W'(k));
        assign pa_we    = clr_here || bus.a_we;
        assign pa_addr  = clr_here ? clr_addr_q : bus.a_addr;
        assign pa_wdata = clr_here ? '0 : encode(bus.a_wdata);
        assign pb_en    = b_acc && bus.b_bank == BSEL_W'(k);

        // Read-first on both ports; port B's write lands last so it wins a double write.
        always_ff @(posedge sysclk) begin
            if (pa_en) begin
                if (pa_we) begin
                    mem[pa_addr] <= pa_wdata;
                end
                qa <= mem[pa_addr];
            end
            if (pb_en) begin
                if (bus.b_we) begin
                    mem[bus.b_addr] <= encode(bus.b_wdata);
                end
                qb <= mem[bus.b_addr];
            end
        end

        assign qa_all[k] = qa;
        assign qb_all[k] = qb;
    end

    always_ff @(posedge sysclk or negedge arduino_reset_n) begin
        if (!arduino_reset_n) begin
            a_v1      <= 1'b0;
            a_rd1     <= 1'b0;
            a_ok1     <= 1'b0;
            a_bank1   <= '0;
            a_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            a_perr_q  <= 1'b0;
        end else begin
            a_v1     <= a_acc;
            a_rd1    <= !bus.a_we;
            a_ok1    <= in_range(bus.a_bank);
            a_bank1  <= bus.a_bank;
            a_ack_q  <= a_v1;
            a_perr_q <= 1'b0;
            if (a_v1 && a_rd1) begin
                if (a_ok1) begin
                    a_rdata_q <= qa_all[a_bank1][DATA_W-1:0];
`ifdef MEMBANK_PARITY_EN
                    a_perr_q  <= ^qa_all[a_bank1];
`endif
                end else begin
                    a_rdata_q <= '0;
                end
            end
        end
    end

    always_ff @(posedge sysclk or negedge arduino_reset_n) begin
        if (!arduino_reset_n) begin
            b_v1      <= 1'b0;
            b_rd1     <= 1'b0;
            b_ok1     <= 1'b0;
            b_bank1   <= '0;
            b_ack_q   <= 1'b0;
            b_rdata_q <= '0;
            b_perr_q  <= 1'b0;
        end else begin
            b_v1     <= b_acc;
            b_rd1    <= !bus.b_we;
            b_ok1    <= in_range(bus.b_bank);
            b_bank1  <= bus.b_bank;
            b_ack_q  <= b_v1;
            b_perr_q <= 1'b0;
            if (b_v1 && b_rd1) begin
                if (b_ok1) begin
                    b_rdata_q <= qb_all[b_bank1][DATA_W-1:0];
`ifdef MEMBANK_PARITY_EN
                    b_perr_q  <= ^qb_all[b_bank1];
`endif
                end else begin
                    b_rdata_q <= '0;
                end
            end
        end
    end

    // A clear request in the same cycle outranks a new collision.
    always_ff @(posedge sysclk or negedge arduino_reset_n) begin
        if (!arduino_reset_n) begin
            coll_cnt_q  <= '0;
            coll_flag_q <= 1'b0;
        end else if (bus.collision_clr) begin
            coll_cnt_q  <= '0;
            coll_flag_q <= 1'b0;
        end else if (collision) begin
            coll_flag_q <= 1'b1;
            if (coll_cnt_q != 16'hFFFF) begin
                coll_cnt_q <= coll_cnt_q + 16'd1;
            end
        end
    end

    assign bus.a_ready        = a_ready_s;
    assign bus.b_ready        = b_ready_s;
    assign bus.a_ack          = a_ack_q;
    assign bus.b_ack          = b_ack_q;
    assign bus.a_rdata        = a_rdata_q;
    assign bus.b_rdata        = b_rdata_q;
    assign bus.a_perr         = a_perr_q;
    assign bus.b_perr         = b_perr_q;
    assign bus.clear_busy     = clearing;
    assign bus.clear_done     = clear_done_s;
    assign bus.collision_cnt  = coll_cnt_q;
    assign bus.collision_flag = coll_flag_q;
endmodule

// File: tb/tb_mem_bank_array.sv
// Randomised scoreboard bench for mem_bank_array (4 banks x 16 words x 8 bits).
// Expected responses come from an array model; a negedge monitor pops and compares them.
module tb_mem_bank_array;
    localparam int NB    = 4;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    typedef struct {
        logic          a_req;
        logic [1:0]    a_bank;
        logic [AW-1:0] a_addr;
        logic          a_we;
        logic [DW-1:0] a_wd;
        logic          b_req;
        logic [1:0]    b_bank;
        logic [AW-1:0] b_addr;
        logic          b_we;
        logic [DW-1:0] b_wd;
        logic          clr_start;
        logic [1:0]    clr_bank;
        logic          coll_clr;
    } stim_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          perr;
        int            cyc;
    } exp_t;

    logic sysclk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    mem_bank_array_if #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_bank_array #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW)) dut (
        .sysclk          (sysclk),
        .arduino_reset_n (rst_n),
        .bus             (bus.slave)
    );

    logic [DW-1:0] mdl   [NB][DEPTH];
    logic          pflip [NB][DEPTH];
    logic [DW-1:0] last_a, last_b;
    int            clr_left;
    logic [1:0]    clr_bank_m;
    logic          done_m;
    int            cnt_m;
    logic          flag_m;
    exp_t          qa[$];
    exp_t          qb[$];

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Drives one cycle: checks the visible state against the model, then advances the model.
    task automatic applyStimulus(input stim_t s);
        logic exp_busy, exp_ar, exp_br, a_acc, b_acc, done_next;
        exp_t ea, eb;
        bus.a_req = s.a_req; bus.a_bank = s.a_bank; bus.a_addr = s.a_addr;
        bus.a_we = s.a_we; bus.a_wdata = s.a_wd;
        bus.b_req = s.b_req; bus.b_bank = s.b_bank; bus.b_addr = s.b_addr;
        bus.b_we = s.b_we; bus.b_wdata = s.b_wd;
        bus.clear_start = s.clr_start; bus.clear_bank = s.clr_bank;
        bus.collision_clr = s.coll_clr;
        #1;
        exp_busy = (clr_left > 0);
        exp_ar   = !(exp_busy && s.a_bank == clr_bank_m);
        exp_br   = !(exp_busy && s.b_bank == clr_bank_m);
        checkOutput("clear_busy", bus.clear_busy, exp_busy);
        checkOutput("clear_done", bus.clear_done, done_m);
        checkOutput("a_ready", bus.a_ready, exp_ar);
        checkOutput("b_ready", bus.b_ready, exp_br);
        checkOutput("collision_cnt", bus.collision_cnt, cnt_m);
        checkOutput("collision_flag", bus.collision_flag, flag_m);
        a_acc = s.a_req && exp_ar;
        b_acc = s.b_req && exp_br;
        if (a_acc) begin
            ea.cyc = cyc + 2;
            ea.perr = 1'b0;
            if (!s.a_we) begin
                ea.rdata = mdl[s.a_bank][s.a_addr];
                ea.perr  = pflip[s.a_bank][s.a_addr];
                last_a   = ea.rdata;
            end else begin
                ea.rdata = last_a;
            end
            qa.push_back(ea);
        end
        if (b_acc) begin
            eb.cyc = cyc + 2;
            eb.perr = 1'b0;
            if (!s.b_we) begin
                eb.rdata = mdl[s.b_bank][s.b_addr];
                eb.perr  = pflip[s.b_bank][s.b_addr];
                last_b   = eb.rdata;
            end else begin
                eb.rdata = last_b;
            end
            qb.push_back(eb);
        end
        if (a_acc && s.a_we) begin
            mdl[s.a_bank][s.a_addr] = s.a_wd;
            pflip[s.a_bank][s.a_addr] = 1'b0;
        end
        if (b_acc && s.b_we) begin
            mdl[s.b_bank][s.b_addr] = s.b_wd;
            pflip[s.b_bank][s.b_addr] = 1'b0;
        end
        if (s.coll_clr) begin
            cnt_m = 0;
            flag_m = 1'b0;
        end else if (a_acc && b_acc && s.a_bank == s.b_bank && s.a_addr == s.b_addr
                     && (s.a_we || s.b_we)) begin
            flag_m = 1'b1;
            if (cnt_m < 65535) cnt_m++;
        end
        done_next = 1'b0;
        if (clr_left > 0) begin
            mdl[clr_bank_m][DEPTH - clr_left] = '0;
            pflip[clr_bank_m][DEPTH - clr_left] = 1'b0;
            clr_left--;
            if (clr_left == 0) done_next = 1'b1;
        end else if (!done_m && s.clr_start) begin
            clr_bank_m = s.clr_bank;
            clr_left = DEPTH;
        end
        done_m = done_next;
        @(posedge sysclk);
        #1;
    endtask

    // Scoreboard monitor: every ack must match the oldest expectation, in the promised cycle.
    always @(negedge sysclk) begin
        exp_t e;
        if (rst_n) begin
            while (qa.size() > 0 && qa[0].cyc < cyc) begin
                n_checks++; n_fail++;
                $display("[TB] FAIL a_ack_missing: got no ack expected ack in cycle %0d", qa[0].cyc);
                void'(qa.pop_front());
            end
            if (bus.a_ack) begin
                if (qa.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("[TB] FAIL a_ack_unexpected: got ack expected none (cycle %0d)", cyc);
                end else begin
                    e = qa.pop_front();
                    checkOutput("a_ack_cycle", cyc, e.cyc);
                    checkOutput("a_rdata", bus.a_rdata, e.rdata);
                    checkOutput("a_perr", bus.a_perr, e.perr);
                end
            end
            while (qb.size() > 0 && qb[0].cyc < cyc) begin
                n_checks++; n_fail++;
                $display("[TB] FAIL b_ack_missing: got no ack expected ack in cycle %0d", qb[0].cyc);
                void'(qb.pop_front());
            end
            if (bus.b_ack) begin
                if (qb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("[TB] FAIL b_ack_unexpected: got ack expected none (cycle %0d)", cyc);
                end else begin
                    e = qb.pop_front();
                    checkOutput("b_ack_cycle", cyc, e.cyc);
                    checkOutput("b_rdata", bus.b_rdata, e.rdata);
                    checkOutput("b_perr", bus.b_perr, e.perr);
                end
            end
        end
    end

    initial begin
        stim_t s;
        cyc = 0; n_checks = 0; n_fail = 0;
        clr_left = 0; clr_bank_m = '0; done_m = 1'b0; cnt_m = 0; flag_m = 1'b0;
        last_a = '0; last_b = '0;
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEPTH; a++) begin
                mdl[b][a] = 'x;
                pflip[b][a] = 1'b0;
            end
        rst_n = 1'b0;
        bus.a_req = 0; bus.a_bank = 0; bus.a_addr = 0; bus.a_we = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_bank = 0; bus.b_addr = 0; bus.b_we = 0; bus.b_wdata = 0;
        bus.clear_start = 0; bus.clear_bank = 0; bus.collision_clr = 0;
        #12;
        checkOutput("reset_a_ack", bus.a_ack, 0);
        checkOutput("reset_b_ack", bus.b_ack, 0);
        checkOutput("reset_a_rdata", bus.a_rdata, 0);
        checkOutput("reset_b_rdata", bus.b_rdata, 0);
        checkOutput("reset_clear_busy", bus.clear_busy, 0);
        checkOutput("reset_clear_done", bus.clear_done, 0);
        checkOutput("reset_collision_cnt", bus.collision_cnt, 0);
        checkOutput("reset_collision_flag", bus.collision_flag, 0);
        @(posedge sysclk); #1;
        rst_n = 1'b1;

        $display("[TB] zero-fill every bank");
        for (int b = 0; b < NB; b++) begin
            s = idle(); s.clr_start = 1'b1; s.clr_bank = 2'(b);
            applyStimulus(s);
            for (int i = 0; i < DEPTH + 1; i++) applyStimulus(idle());
        end

        $display("[TB] write then read bank1, other banks untouched");
        s = idle(); s.a_req = 1; s.a_bank = 1; s.a_addr = 4'hA; s.a_we = 1; s.a_wd = 8'hA5;
        applyStimulus(s);
        s.a_we = 0;
        applyStimulus(s);
        for (int b = 0; b < NB; b++) begin
            s = idle(); s.b_req = 1; s.b_bank = 2'(b); s.b_addr = 4'hA;
            applyStimulus(s);
        end

        $display("[TB] back-to-back reads on bank2");
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.a_req = 1; s.a_bank = 2; s.a_addr = 4'(i); s.a_we = 1; s.a_wd = 8'(8'h11 + i);
            applyStimulus(s);
        end
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.b_req = 1; s.b_bank = 2; s.b_addr = 4'(i);
            applyStimulus(s);
        end

        $display("[TB] double-write collision on bank0");
        s = idle(); s.a_req = 1; s.a_bank = 0; s.a_addr = 5; s.a_we = 1; s.a_wd = 8'h33;
        s.b_req = 1; s.b_bank = 0; s.b_addr = 5; s.b_we = 1; s.b_wd = 8'h44;
        applyStimulus(s);
        s = idle(); s.a_req = 1; s.a_bank = 0; s.a_addr = 5;
        applyStimulus(s);
        applyStimulus(idle());
        s = idle(); s.coll_clr = 1'b1;
        applyStimulus(s);
        applyStimulus(idle());

        $display("[TB] read-first collision on bank3");
        s = idle(); s.a_req = 1; s.a_bank = 3; s.a_addr = 7; s.a_we = 1; s.a_wd = 8'h01;
        applyStimulus(s);
        s = idle(); s.a_req = 1; s.a_bank = 3; s.a_addr = 7;
        s.b_req = 1; s.b_bank = 3; s.b_addr = 7; s.b_we = 1; s.b_wd = 8'h99;
        applyStimulus(s);
        s = idle(); s.a_req = 1; s.a_bank = 3; s.a_addr = 7;
        applyStimulus(s);

        $display("[TB] clear bank2 with bank0 traffic alongside");
        s = idle(); s.clr_start = 1; s.clr_bank = 2;
        s.a_req = 1; s.a_bank = 2; s.a_addr = 1; s.a_we = 1; s.a_wd = 8'h5A;
        applyStimulus(s);
        for (int i = 0; i < DEPTH + 2; i++) begin
            s = idle();
            s.a_req = 1; s.a_bank = 0; s.a_addr = 4'(i); s.a_we = i[0]; s.a_wd = 8'($urandom);
            s.b_req = 1; s.b_bank = 2; s.b_addr = 4'(i);
            s.clr_start = (i == 3); s.clr_bank = 1;
            applyStimulus(s);
        end
        for (int i = 0; i < DEPTH; i++) begin
            s = idle(); s.b_req = 1; s.b_bank = 2; s.b_addr = 4'(i);
            applyStimulus(s);
        end

`ifdef MEMBANK_PARITY_EN
        $display("[TB] corrupt a stored bit in bank1");
        s = idle(); s.a_req = 1; s.a_bank = 1; s.a_addr = 3; s.a_we = 1; s.a_wd = 8'h6C;
        applyStimulus(s);
        applyStimulus(idle());
        dut.g_bank[1].mem[3] = dut.g_bank[1].mem[3] ^ 9'h001;
        mdl[1][3] = mdl[1][3] ^ 8'h01;
        pflip[1][3] = 1'b1;
        s = idle(); s.b_req = 1; s.b_bank = 1; s.b_addr = 3;
        applyStimulus(s);
        s = idle(); s.a_req = 1; s.a_bank = 1; s.a_addr = 3; s.a_we = 1; s.a_wd = 8'h6C;
        applyStimulus(s);
`endif

        $display("[TB] randomised traffic");
        for (int i = 0; i < 400; i++) begin
            logic narrow;
            narrow = ($urandom_range(0, 1) == 0);
            s.a_req = ($urandom_range(0, 3) != 0);
            s.a_bank = 2'($urandom_range(0, NB - 1));
            s.a_addr = narrow ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, DEPTH - 1));
            s.a_we = 1'($urandom_range(0, 1));
            s.a_wd = 8'($urandom);
            s.b_req = ($urandom_range(0, 3) != 0);
            s.b_bank = narrow ? s.a_bank : 2'($urandom_range(0, NB - 1));
            s.b_addr = narrow ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, DEPTH - 1));
            s.b_we = 1'($urandom_range(0, 1));
            s.b_wd = 8'($urandom);
            s.clr_start = ($urandom_range(0, 40) == 0);
            s.clr_bank = 2'($urandom_range(0, NB - 1));
            s.coll_clr = ($urandom_range(0, 30) == 0);
            applyStimulus(s);
        end

        for (int i = 0; i < DEPTH + 4; i++) applyStimulus(idle());
        checkOutput("a_queue_drained", qa.size(), 0);
        checkOutput("b_queue_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
